// File: rtl/rs_gf16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_gf16_pkg
// Description : Shared GF(16) arithmetic and RS(15,9) code geometry.
//               Field: p(x) = x^4 + x + 1, alpha = 4'b0010.
//               Generator g(x) = prod_{i=1..6} (x + alpha^i)
//                              = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C.
//               Parity register layout: parity[4i+:4] holds r_i (i = 0..5).
// Revision    : 1.0 - initial release
// ============================================================================
package rs_gf16_pkg;

    localparam int GF_WIDTH = 4;
    localparam int N        = 15;
    localparam int K        = 9;
    localparam int NPAR     = N - K;

    localparam logic [4:0] PRIM_POLY = 5'b1_0011;

    localparam logic [3:0] G0 = 4'hC;
    localparam logic [3:0] G1 = 4'hA;
    localparam logic [3:0] G2 = 4'hC;
    localparam logic [3:0] G3 = 4'h3;
    localparam logic [3:0] G4 = 4'h9;
    localparam logic [3:0] G5 = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } encState_t;

    // Carry-less 4x4 product followed by reduction with x^4 = x + 1:
    //   x^4 -> bits 1,0   x^5 -> bits 2,1   x^6 -> bits 3,2
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] c;
        c[0] = a[0] & b[0];
        c[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
        c[3] = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ (a[0] & b[3]);
        c[4] = (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
        c[5] = (a[3] & b[2]) ^ (a[2] & b[3]);
        c[6] = a[3] & b[3];
        return {c[3] ^ c[6], c[2] ^ c[5] ^ c[6], c[1] ^ c[4] ^ c[5], c[0] ^ c[4]};
    endfunction

    // One step of the systematic-encoder division LFSR.
    function automatic logic [23:0] lfsr_step(input logic [23:0] par, input logic [3:0] sym);
        logic [3:0]  f;
        logic [23:0] nxt;
        f          = sym ^ par[23:20];
        nxt[23:20] = par[19:16] ^ gf16_mul(G5, f);
        nxt[19:16] = par[15:12] ^ gf16_mul(G4, f);
        nxt[15:12] = par[11:8]  ^ gf16_mul(G3, f);
        nxt[11:8]  = par[7:4]   ^ gf16_mul(G2, f);
        nxt[7:4]   = par[3:0]   ^ gf16_mul(G1, f);
        nxt[3:0]   = gf16_mul(G0, f);
        return nxt;
    endfunction

endpackage : rs_gf16_pkg
`default_nettype wire

// File: rtl/rs_parity_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rs_parity_lfsr
// Description : Six-stage GF(16) parity LFSR (r0..r5) with constant
//               generator multipliers. One message symbol per enabled clock.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               clear    - synchronous clear of r0..r5
//               shift_en - consume sym_in this clock
//               sym_in   - message symbol, highest degree first
//               parity   - {r5,r4,r3,r2,r1,r0}
// Revision    : 1.0 - initial release
// ============================================================================
module rs_parity_lfsr
    import rs_gf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [3:0]  sym_in,
    output logic [23:0] parity
);

    logic [23:0] r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= '0;
        end else if (clear) begin
            r_parity <= '0;
        end else if (shift_en) begin
            r_parity <= lfsr_step(r_parity, sym_in);
        end
    end

    assign parity = r_parity;

endmodule : rs_parity_lfsr
`default_nettype wire

// File: rtl/rs15_9_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rs15_9_encoder
// Description : Sequential systematic RS(15,9) encoder over GF(16).
//               Message symbol k lands at codeword position 6+k; parity
//               occupies positions 0..5. Nine SHIFT cycles feed m8..m0 into
//               the parity LFSR, then the codeword is held in DONE until
//               the consumer accepts it.
// Ports       : clk           - rising-edge clock
//               rst_n         - asynchronous active-low reset
//               messageIn     - 9 symbols, symbol k = messageIn[4k+:4]
//               encodeMessage - start request, sampled only in IDLE
//               encoderBusy   - high in SHIFT and DONE
//               codeWordOut   - 15 symbols, position i = codeWordOut[4i+:4]
//               codeWordValid - codeWordOut holds a complete codeword
//               codeWordReady - consumer accepts the codeword
// Revision    : 1.0 - initial release
// ============================================================================
module rs15_9_encoder
    import rs_gf16_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [GF_WIDTH*K-1:0]      messageIn,
    input  logic                       encodeMessage,
    output logic                       encoderBusy,
    output logic [GF_WIDTH*N-1:0]      codeWordOut,
    output logic                       codeWordValid,
    input  logic                       codeWordReady
);

    localparam logic [3:0] c_LAST_SYM = 4'(K - 1);

    encState_t                  r_state;
    encState_t                  w_stateNext;
    logic [3:0]                 r_symCount;
    logic [GF_WIDTH*K-1:0]      r_message;
    logic [GF_WIDTH*N-1:0]      r_codeWord;

    logic                       w_accept;
    logic                       w_shifting;
    logic                       w_shiftLast;
    logic [3:0]                 w_symIdx;
    logic [3:0]                 w_symIn;
    logic [23:0]                w_parity;

    assign w_accept    = (r_state == ST_IDLE) && encodeMessage;
    assign w_shifting  = (r_state == ST_SHIFT);
    assign w_shiftLast = w_shifting && (r_symCount == c_LAST_SYM);

    // Highest-degree symbol first: counter 0 selects m8, counter 8 selects m0.
    assign w_symIdx = c_LAST_SYM - r_symCount;

    always_comb begin
        w_symIn = 4'h0;
        for (int k = 0; k < K; k++) begin
            if (w_symIdx == 4'(k)) begin
                w_symIn = r_message[GF_WIDTH*k +: GF_WIDTH];
            end
        end
    end

    rs_parity_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_accept),
        .shift_en (w_shifting),
        .sym_in   (w_symIn),
        .parity   (w_parity)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (encodeMessage) w_stateNext = ST_SHIFT;
            ST_SHIFT: if (r_symCount == c_LAST_SYM) w_stateNext = ST_DONE;
            ST_DONE:  if (codeWordReady) w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_symCount <= '0;
            r_message  <= '0;
            r_codeWord <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_message  <= messageIn;
                r_symCount <= '0;
            end else if (w_shifting) begin
                r_symCount <= r_symCount + 4'd1;
            end
            // The LFSR register only reflects the last symbol after this edge,
            // so the final parity is taken from the same step function here.
            if (w_shiftLast) begin
                r_codeWord <= {r_message, lfsr_step(w_parity, w_symIn)};
            end
        end
    end

    assign encoderBusy   = (r_state != ST_IDLE);
    assign codeWordValid = (r_state == ST_DONE);
    assign codeWordOut   = r_codeWord;

endmodule : rs15_9_encoder
`default_nettype wire

// File: tb/tb_rs15_9_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs15_9_encoder
// Description : Self-checking bench for rs15_9_encoder. A transaction-level
//               model computes codewords by polynomial long division with a
//               generator built from its roots; a compare process checks
//               busy/valid/codeword on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs15_9_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] messageIn;
    logic        encodeMessage;
    logic        encoderBusy;
    logic [59:0] codeWordOut;
    logic        codeWordValid;
    logic        codeWordReady;

    int nCompared = 0;
    int nFailed   = 0;
    bit checkOn   = 1'b0;

    localparam logic [59:0] UNIT_CW = 60'h000000001793CAC;

    always #5 clk = ~clk;

    rs15_9_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .messageIn     (messageIn),
        .encodeMessage (encodeMessage),
        .encoderBusy   (encoderBusy),
        .codeWordOut   (codeWordOut),
        .codeWordValid (codeWordValid),
        .codeWordReady (codeWordReady)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- GF(16) reference arithmetic ----------------
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = 4'h0;
        logic [3:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] alphaPow(input int e);
        logic [3:0] v = 4'h1;
        for (int i = 0; i < e; i++) v = gmul(v, 4'h2);
        return v;
    endfunction

    function automatic logic [59:0] refEncode(input logic [35:0] msg);
        logic [3:0]  g [0:6];
        logic [3:0]  c [0:14];
        logic [3:0]  coef;
        logic [59:0] cw;
        // g(x) built from its roots alpha^1..alpha^6
        for (int j = 0; j <= 6; j++) g[j] = (j == 0) ? 4'h1 : 4'h0;
        for (int i = 1; i <= 6; i++) begin
            for (int j = 6; j >= 0; j--) begin
                g[j] = ((j > 0) ? g[j-1] : 4'h0) ^ gmul(alphaPow(i), g[j]);
            end
        end
        for (int p = 0; p < 15; p++) c[p] = (p >= 6) ? msg[4*(p-6) +: 4] : 4'h0;
        for (int d = 14; d >= 6; d--) begin
            coef = c[d];
            for (int j = 0; j <= 6; j++) c[d-6+j] = c[d-6+j] ^ gmul(coef, g[j]);
        end
        cw = '0;
        cw[59:24] = msg;
        for (int p = 0; p < 6; p++) cw[4*p +: 4] = c[p];
        return cw;
    endfunction

    function automatic logic [3:0] syndromeOf(input logic [59:0] cw, input int i);
        logic [3:0] s = 4'h0;
        logic [3:0] a = alphaPow(i);
        for (int j = 14; j >= 0; j--) s = gmul(s, a) ^ cw[4*j +: 4];
        return s;
    endfunction

    // ---------------- transaction-level model ----------------
    // phase 0: idle, 1: encoding (9 symbol cycles), 2: codeword offered
    int          mPhase;
    int          mCount;
    logic [35:0] mMsg;
    logic        mBusy;
    logic        mValid;
    logic [59:0] mCw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase = 0; mCount = 0; mMsg = '0;
            mBusy = 1'b0; mValid = 1'b0; mCw = '0;
        end else begin
            case (mPhase)
                0: if (encodeMessage) begin
                       mMsg = messageIn; mCount = 0; mPhase = 1; mBusy = 1'b1;
                   end
                1: begin
                       mCount++;
                       if (mCount == 9) begin
                           mPhase = 2; mValid = 1'b1; mCw = refEncode(mMsg);
                       end
                   end
                default: if (codeWordReady) begin
                       mPhase = 0; mValid = 1'b0; mBusy = 1'b0;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            check("busy", 64'(encoderBusy), 64'(mBusy));
            check("valid", 64'(codeWordValid), 64'(mValid));
            check("codeword", 64'(codeWordOut), 64'(mCw));
        end
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    task automatic waitIdle();
        encodeMessage = 1'b0;
        codeWordReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!encoderBusy) break;
            @(posedge clk); #2;
        end
        check("idle_wait", 64'(encoderBusy), 64'd0);
        codeWordReady = 1'b0;
    endtask

    // Latency is counted from the edge that launches the request (the edge
    // after which encodeMessage is driven high).
    task automatic runMsg(input logic [35:0] msg, input logic [59:0] expCw,
                          input bit readyEarly, input int hold, input bit poke,
                          input bit hsStart);
        int lat;
        waitIdle();
        messageIn     = msg;
        encodeMessage = 1'b1;
        codeWordReady = readyEarly;
        for (lat = 1; lat <= 30; lat++) begin
            @(posedge clk); #1;
            if (codeWordValid) break;
            #1;
            encodeMessage = (poke && !readyEarly) ? 1'($urandom_range(0, 1)) : 1'b0;
            messageIn     = 36'({$urandom(), $urandom()});
        end
        check("latency", 64'(lat), 64'd10);
        check("cw_at_valid", 64'(codeWordOut), 64'(expCw));
        for (int s = 1; s <= 6; s++) check($sformatf("syndrome_S%0d", s), 64'(syndromeOf(codeWordOut, s)), 64'd0);
        #1;
        if (readyEarly) begin
            encodeMessage = 1'b0;
            @(posedge clk); #2;
            codeWordReady = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                encodeMessage = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                messageIn     = 36'({$urandom(), $urandom()});
                @(posedge clk); #2;
            end
            check("held_codeword", 64'(codeWordOut), 64'(expCw));
            encodeMessage = hsStart;
            codeWordReady = 1'b1;
            @(posedge clk); #2;
            codeWordReady = 1'b0;
            if (hsStart) begin
                // request still high in IDLE: accepted now
                messageIn = 36'({$urandom(), $urandom()});
                @(posedge clk); #2;
            end
            encodeMessage = 1'b0;
        end
    endtask

    initial begin
        logic [35:0] msg;
        rst_n         = 1'b0;
        messageIn     = '0;
        encodeMessage = 1'b0;
        codeWordReady = 1'b0;
        #1;
        check("reset_busy", 64'(encoderBusy), 64'd0);
        check("reset_valid", 64'(codeWordValid), 64'd0);
        check("reset_cw", 64'(codeWordOut), 64'd0);

        // pin the model itself with hand-derived values
        check("model_zero", 64'(refEncode(36'h0)), 64'd0);
        check("model_unit", 64'(refEncode(36'h1)), 64'(UNIT_CW));
        check("model_unit_S3", 64'(syndromeOf(UNIT_CW, 3)), 64'd0);

        @(posedge clk); @(posedge clk); #2;
        rst_n   = 1'b1;
        checkOn = 1'b1;

        runMsg(36'h0, 60'h0, 1'b1, 0, 1'b0, 1'b0);
        check("idle_after_zero", 64'(encoderBusy), 64'd0);
        runMsg(36'h1, UNIT_CW, 1'b0, 2, 1'b0, 1'b0);
        // backpressure with ignored start requests during SHIFT and DONE
        msg = 36'hA5C3_1F07E;
        runMsg(msg, refEncode(msg), 1'b0, 20, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("no_second_cw", 64'(codeWordValid), 64'd0);

        for (int n = 0; n < 150; n++) begin
            msg = 36'({$urandom(), $urandom()});
            runMsg(msg, refEncode(msg), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0));
        end

        // reset while counter is 4
        waitIdle();
        messageIn     = 36'h9_8765_4321;
        encodeMessage = 1'b1;
        @(posedge clk); #2;
        encodeMessage = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(encoderBusy), 64'd0);
        check("abort_valid", 64'(codeWordValid), 64'd0);
        check("abort_cw", 64'(codeWordOut), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        runMsg(36'h1, UNIT_CW, 1'b1, 0, 1'b0, 1'b0);
        waitIdle();

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule : tb_rs15_9_encoder
`default_nettype wire
